// File: rtl/sha256_block_sequencer.sv
// rtl/sha256_block_sequencer.sv - control sequencer for a SHA-256 nonce search
//
// Steps a SHA-256 datapath through the three compression blocks of a
// header-hash nonce search: header chunk 1, header chunk 2, then the second hash.
// After each nonce, the external hash_hit flag decides whether to stop or retry.
//
// Optional feature: define MIDSTATE_REUSE_EN so that a miss restarts at Block 2
// and reuses the Block-1 midstate. Without it, a miss spends one cycle with
// Block=0 (H reload) and restarts at Block 1.
//
// Parameters
//   ROUNDS      compression rounds per message block (1..64)
// Ports
//   clk         sole clock, rising edge
//   rst         asynchronous active-high reset
//   start       begin a nonce search (honoured only in IDLE)
//   abort       cancel the search from any state; wins over every transition
//   nonce_base  first nonce, captured when start is accepted
//   hash_hit    digest-meets-target flag, sampled in CHECK
//   Block       H0..H7 block select: 0 default, 1/2 header chunks, 3 second hash
//   round       current round index
//   load_w      one-cycle pulse that loads the message schedule
//   round_en    a compression round is active
//   h_update    one-cycle pulse that commits a+H for the current Block
//   nonce       nonce under test
//   busy        high whenever the sequencer is not idle
//   found       last search ended on a hit
//   exhausted   last search ran past 32'hFFFFFFFF without a hit
module sha256_block_sequencer #(
    parameter int ROUNDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] nonce_base,
    input  logic        hash_hit,
    output logic [1:0]  Block,
    output logic [5:0]  round,
    output logic        load_w,
    output logic        round_en,
    output logic        h_update,
    output logic [31:0] nonce,
    output logic        busy,
    output logic        found,
    output logic        exhausted
);

    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

    // RELOAD is the single Block=0 cycle that restores the default H values
    // between nonces. It is reachable only when midstate reuse is disabled.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        ROUND  = 3'd2,
        UPDATE = 3'd3,
        CHECK  = 3'd4,
        RELOAD = 3'd5
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [1:0]  block_d;
    logic [5:0]  round_d;
    logic [31:0] nonce_d;
    logic        found_d;
    logic        exhausted_d;
    logic        load_w_d;
    logic        round_en_d;
    logic        h_update_d;

    // State register, with the outputs registered alongside so every strobe
    // leaves a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            Block     <= 2'd0;
            round     <= 6'd0;
            nonce     <= 32'd0;
            found     <= 1'b0;
            exhausted <= 1'b0;
            load_w    <= 1'b0;
            round_en  <= 1'b0;
            h_update  <= 1'b0;
        end else begin
            state     <= next_state;
            Block     <= block_d;
            round     <= round_d;
            nonce     <= nonce_d;
            found     <= found_d;
            exhausted <= exhausted_d;
            load_w    <= load_w_d;
            round_en  <= round_en_d;
            h_update  <= h_update_d;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (start) next_state = LOAD;
            LOAD:   next_state = ROUND;
            ROUND:  if (round == LAST_ROUND) next_state = UPDATE;
            UPDATE: next_state = (Block == 2'd3) ? CHECK : LOAD;
            CHECK: begin
                if (hash_hit || nonce == 32'hFFFF_FFFF) begin
                    next_state = IDLE;
                end else begin
`ifdef MIDSTATE_REUSE_EN
                    next_state = LOAD;
`else
                    next_state = RELOAD;
`endif
                end
            end
            RELOAD: next_state = LOAD;
            default: next_state = IDLE;
        endcase
        if (abort) next_state = IDLE;
    end

    // Output logic: produces the D-side of the registered outputs
    always_comb begin
        block_d     = Block;
        nonce_d     = nonce;
        found_d     = found;
        exhausted_d = exhausted;
        case (state)
            IDLE: begin
                if (start) begin
                    nonce_d     = nonce_base;
                    found_d     = 1'b0;
                    exhausted_d = 1'b0;
                    block_d     = 2'd1;
                end
            end
            UPDATE: begin
                if (Block != 2'd3) block_d = Block + 2'd1;
            end
            CHECK: begin
                if (hash_hit) begin
                    found_d = 1'b1;
                    block_d = 2'd0;
                end else if (nonce == 32'hFFFF_FFFF) begin
                    // Stop rather than wrap, so no nonce is ever tested twice.
                    exhausted_d = 1'b1;
                    block_d     = 2'd0;
                end else begin
                    nonce_d = nonce + 32'd1;
`ifdef MIDSTATE_REUSE_EN
                    block_d = 2'd2;
`else
                    block_d = 2'd0;
`endif
                end
            end
            RELOAD: block_d = 2'd1;
            default: ;
        endcase
        // An abort keeps nonce and the status flags exactly as they were.
        if (abort) begin
            block_d     = 2'd0;
            nonce_d     = nonce;
            found_d     = found;
            exhausted_d = exhausted;
        end

        // The round index holds at 0 through LOAD and UPDATE. It advances only
        // while ROUND continues, so it never wraps inside a block.
        round_d    = (state == ROUND && next_state == ROUND) ? round + 6'd1 : 6'd0;
        load_w_d   = (next_state == LOAD);
        round_en_d = (next_state == ROUND);
        h_update_d = (next_state == UPDATE);
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// tb/tb_sha256_block_sequencer.sv - directed self-checking bench for sha256_block_sequencer
module tb_sha256_block_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] nonce_base;
    logic        hash_hit;
    logic [1:0]  Block;
    logic [5:0]  round;
    logic        load_w;
    logic        round_en;
    logic        h_update;
    logic [31:0] nonce;
    logic        busy;
    logic        found;
    logic        exhausted;

`ifdef MIDSTATE_REUSE_EN
    localparam int RETRY_SPACING = 133;
    localparam int FOUND_CYC_T2  = 465;
`else
    localparam int RETRY_SPACING = 200;
    localparam int FOUND_CYC_T2  = 599;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int excl_bad    = 0;

    sha256_block_sequencer #(.ROUNDS(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .nonce_base (nonce_base),
        .hash_hit   (hash_hit),
        .Block      (Block),
        .round      (round),
        .load_w     (load_w),
        .round_en   (round_en),
        .h_update   (h_update),
        .nonce      (nonce),
        .busy       (busy),
        .found      (found),
        .exhausted  (exhausted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Strobes must be one-hot-or-zero, and all zero whenever the sequencer is idle.
    always @(negedge clk) begin
        if (!rst) begin
            if (int'(load_w) + int'(round_en) + int'(h_update) > 1) excl_bad++;
            if (!busy && (load_w || round_en || h_update)) excl_bad++;
        end
    end

    // The posedge sampling start is the start edge. The following negedge is cycle 0.
    task automatic do_start(input logic [31:0] base);
        @(negedge clk);
        nonce_base = base;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start      = 1'b0;
    endtask

    int hu_cyc [3];
    int hu_blk [3];
    int hu_n;
    int upd3 [$];
    int found_cyc;

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        nonce_base = 32'd0;
        hash_hit   = 1'b0;
        #12;
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_block", 32'(Block), 32'd0);
        check("rst_nonce", nonce, 32'd0);
        check("rst_round", 32'(round), 32'd0);
        check("rst_flags", {29'd0, found, exhausted, load_w}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single nonce with an immediate hit
        hash_hit = 1'b1;
        do_start(32'h10);
        hu_n = 0;
        for (int k = 0; k <= 199; k++) begin
            @(negedge clk);
            if (h_update) begin
                if (hu_n < 3) begin
                    hu_cyc[hu_n] = k;
                    hu_blk[hu_n] = int'(Block);
                end
                hu_n++;
            end
            if (k == 0) begin
                check("t1_load_w",     32'(load_w), 32'd1);
                check("t1_round_load", 32'(round), 32'd0);
                check("t1_block_load", 32'(Block), 32'd1);
            end
            if (k == 64) begin
                check("t1_round_last", 32'(round), 32'd63);
                check("t1_round_en",   32'(round_en), 32'd1);
            end
            if (k == 198) check("t1_busy_check", {30'd0, busy, found}, 32'd2);
        end
        check("t1_hu_count", 32'(hu_n), 32'd3);
        check("t1_hu0_cyc", 32'(hu_cyc[0]), 32'd65);
        check("t1_hu1_cyc", 32'(hu_cyc[1]), 32'd131);
        check("t1_hu2_cyc", 32'(hu_cyc[2]), 32'd197);
        check("t1_hu_blocks", 32'(hu_blk[0] * 16 + hu_blk[1] * 4 + hu_blk[2]), 32'h1B);
        check("t1_found", 32'(found), 32'd1);
        check("t1_nonce", nonce, 32'h10);
        check("t1_block_end", 32'(Block), 32'd0);
        check("t1_busy_end", 32'(busy), 32'd0);

        // Two misses, then a hit on nonce 7
        hash_hit = 1'b0;
        do_start(32'h5);
        found_cyc = -1;
        for (int k = 0; k <= 700 && found_cyc < 0; k++) begin
            @(negedge clk);
            hash_hit = (nonce == 32'h7);
            if (h_update && Block == 2'd3) upd3.push_back(k);
            if (found) found_cyc = k;
            if (k == 199) begin
`ifdef MIDSTATE_REUSE_EN
                check("t2_retry_block", 32'(Block), 32'd2);
                check("t2_retry_load",  32'(load_w), 32'd1);
`else
                check("t2_reload_block", 32'(Block), 32'd0);
                check("t2_reload_busy",  {30'd0, busy, load_w}, 32'd2);
`endif
            end
        end
        hash_hit = 1'b0;
        check("t2_found_cyc", 32'(found_cyc), 32'(FOUND_CYC_T2));
        check("t2_nonce", nonce, 32'h7);
        check("t2_exhausted", 32'(exhausted), 32'd0);
        check("t2_upd3_count", 32'(upd3.size()), 32'd3);
        if (upd3.size() >= 3) begin
            check("t2_spacing_a", 32'(upd3[1] - upd3[0]), 32'(RETRY_SPACING));
            check("t2_spacing_b", 32'(upd3[2] - upd3[1]), 32'(RETRY_SPACING));
        end

        // Last nonce misses, so the search stops without wrapping
        do_start(32'hFFFF_FFFF);
        repeat (200) @(negedge clk);
        check("t3_exhausted", 32'(exhausted), 32'd1);
        check("t3_nonce", nonce, 32'hFFFF_FFFF);
        check("t3_found", 32'(found), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_block", 32'(Block), 32'd0);

        // Abort with a simultaneous start at round 30 of Block 2
        do_start(32'h100);
        repeat (98) @(negedge clk);
        check("t4_round_at_abort", 32'(round), 32'd30);
        check("t4_block_at_abort", 32'(Block), 32'd2);
        abort      = 1'b1;
        start      = 1'b1;
        nonce_base = 32'h555;
        @(posedge clk);
        #1;
        abort = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_block", 32'(Block), 32'd0);
        check("t4_round", {26'd0, round}, 32'd0);
        check("t4_pulses", {29'd0, load_w, round_en, h_update}, 32'd0);
        check("t4_nonce_held", nonce, 32'h100);
        check("t4_flags", {30'd0, found, exhausted}, 32'd0);
        repeat (3) @(negedge clk);
        check("t4_still_idle", 32'(busy), 32'd0);

        // A start while busy is ignored
        hash_hit = 1'b1;
        do_start(32'h20);
        repeat (51) @(negedge clk);
        start      = 1'b1;
        nonce_base = 32'h99;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("t6_round", 32'(round), 32'd50);
        check("t6_block", 32'(Block), 32'd1);
        check("t6_nonce", nonce, 32'h20);
        repeat (14) @(negedge clk);
        check("t6_hu_cyc65", {30'd0, h_update, round_en}, 32'd2);
        repeat (134) @(negedge clk);
        check("t6_found", 32'(found), 32'd1);
        check("t6_nonce_end", nonce, 32'h20);

        // Asynchronous reset in the middle of ROUND
        do_start(32'h30);
        repeat (21) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_round", 32'(round), 32'd0);
        check("t5_block", 32'(Block), 32'd0);
        check("t5_nonce", nonce, 32'd0);
        check("t5_pulses_flags", {27'd0, round_en, load_w, h_update, found, exhausted}, 32'd0);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_idle_after", 32'(busy), 32'd0);
        do_start(32'h42);
        repeat (200) @(negedge clk);
        check("t5_found", 32'(found), 32'd1);
        check("t5_nonce_end", nonce, 32'h42);

        check("strobe_exclusive", 32'(excl_bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
